// File: rtl/naive_bus_pkg.sv
// Shared definitions for the naive bus crossbar: index widths, the read-source
// encoding (ERR = one past the last slave) and the default unmapped read data.
package naive_bus_pkg;

    localparam logic [31:0] NAIVE_BUS_ERR_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    // Width of an index able to address n distinct values (never below one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rd_src_err(input int n_slave);
        return n_slave;
    endfunction

endpackage

// File: rtl/naive_bus_arbiter.sv
// One N_MASTER-way arbiter for a single slave port: request vector in, one-hot
// grant out. Fixed priority by default; NAIVE_BUS_XBAR_RR_EN adds a round-robin pointer.
module naive_bus_arbiter
    import naive_bus_pkg::*;
#(
    parameter int N_MASTER = 3
) (
`ifdef NAIVE_BUS_XBAR_RR_EN
    input  logic                clk,
    input  logic                rst,
    input  logic                slave_gnt,
`endif
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] grant
);

    logic [N_MASTER-1:0] cand;
    logic                found;

`ifdef NAIVE_BUS_XBAR_RR_EN
    localparam int MIDX_W = idx_width(N_MASTER);

    logic [MIDX_W-1:0]   ptr_q;
    logic [MIDX_W-1:0]   win_idx;
    logic [N_MASTER-1:0] upper_req;

    // Requesters at or above the pointer go first; otherwise wrap to the bottom
    always_comb begin
        upper_req = '0;
        for (int j = 0; j < N_MASTER; j++) begin
            upper_req[j] = req[j] && (j >= int'(ptr_q));
        end
        cand = (|upper_req) ? upper_req : req;
    end
`else
    assign cand = req;
`endif

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N_MASTER; j++) begin
            if (cand[j] && !found) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`ifdef NAIVE_BUS_XBAR_RR_EN
    always_comb begin
        win_idx = '0;
        for (int j = 0; j < N_MASTER; j++) begin
            if (grant[j]) begin
                win_idx = MIDX_W'(j);
            end
        end
    end

    // The pointer only moves once the slave has actually accepted the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (slave_gnt && (|req)) begin
            if (win_idx == MIDX_W'(N_MASTER - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= win_idx + MIDX_W'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/naive_bus_xbar.sv
// N-master / M-slave naive bus crossbar with one arbiter per slave and local
// termination of unmapped accesses. Define NAIVE_BUS_XBAR_RR_EN for round-robin arbiters.
module naive_bus_xbar
    import naive_bus_pkg::*;
#(
    parameter int                    N_MASTER    = 3,
    parameter int                    N_SLAVE     = 5,
    parameter logic [N_SLAVE*32-1:0] SLAVES_MASK = {N_SLAVE{32'h0000_0fff}},
    parameter logic [N_SLAVE*32-1:0] SLAVES_BASE = {32'h0003_0000, 32'h0002_0000,
                                                    32'h0001_0000, 32'h0000_8000,
                                                    32'h0000_0000},
    parameter logic [31:0]           ERR_RDATA   = NAIVE_BUS_ERR_RDATA
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [N_MASTER-1:0]    master_rd_req,
    output logic [N_MASTER-1:0]    master_rd_gnt,
    input  logic [N_MASTER*32-1:0] master_rd_addr,
    output logic [N_MASTER*32-1:0] master_rd_data,
    input  logic [N_MASTER-1:0]    master_wr_req,
    output logic [N_MASTER-1:0]    master_wr_gnt,
    input  logic [N_MASTER*32-1:0] master_wr_addr,
    input  logic [N_MASTER*4-1:0]  master_wr_byte,
    input  logic [N_MASTER*32-1:0] master_wr_data,

    output logic [N_SLAVE-1:0]     slave_rd_req,
    input  logic [N_SLAVE-1:0]     slave_rd_gnt,
    output logic [N_SLAVE*32-1:0]  slave_rd_addr,
    input  logic [N_SLAVE*32-1:0]  slave_rd_data,
    output logic [N_SLAVE-1:0]     slave_wr_req,
    input  logic [N_SLAVE-1:0]     slave_wr_gnt,
    output logic [N_SLAVE*32-1:0]  slave_wr_addr,
    output logic [N_SLAVE*4-1:0]   slave_wr_byte,
    output logic [N_SLAVE*32-1:0]  slave_wr_data,

    output logic                   o_err_pulse,
    output logic [15:0]            o_err_cnt
);

    localparam int SIDX_W  = idx_width(N_SLAVE + 1);
    localparam int ERR_IDX = rd_src_err(N_SLAVE);
    localparam int ECNT_W  = idx_width(N_MASTER + 1);

    acc_kind_e           act_kind   [N_MASTER];
    logic [SIDX_W-1:0]   act_dst    [N_MASTER];
    logic [N_MASTER-1:0] arb_req    [N_SLAVE];
    logic [N_MASTER-1:0] arb_gnt    [N_SLAVE];
    logic [N_MASTER-1:0] route_gnt;
    logic [N_MASTER-1:0] err_hit;
    logic [N_MASTER-1:0] rd_valid_q;
    logic [SIDX_W-1:0]   rd_src_q   [N_MASTER];
    logic [ECNT_W-1:0]   err_num;
    logic [16:0]         err_sum;
    logic                err_pulse_q;
    logic [15:0]         err_cnt_q;

    // Lowest matching slave wins on overlapping windows
    function automatic logic [SIDX_W-1:0] decode(input logic [31:0] addr);
        logic [SIDX_W-1:0] dst;
        dst = SIDX_W'(ERR_IDX);
        for (int s = N_SLAVE - 1; s >= 0; s--) begin
            if ((addr & ~SLAVES_MASK[s*32 +: 32]) == SLAVES_BASE[s*32 +: 32]) begin
                dst = SIDX_W'(s);
            end
        end
        return dst;
    endfunction

    // A master presents one access per cycle; a read shadows a simultaneous write
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            act_kind[m] = ACC_NONE;
            act_dst[m]  = SIDX_W'(ERR_IDX);
            if (master_rd_req[m]) begin
                act_kind[m] = ACC_READ;
                act_dst[m]  = decode(master_rd_addr[m*32 +: 32]);
            end else if (master_wr_req[m]) begin
                act_kind[m] = ACC_WRITE;
                act_dst[m]  = decode(master_wr_addr[m*32 +: 32]);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < N_SLAVE; s++) begin
            arb_req[s] = '0;
            for (int m = 0; m < N_MASTER; m++) begin
                arb_req[s][m] = !rst && (act_kind[m] != ACC_NONE) &&
                                (act_dst[m] == SIDX_W'(s));
            end
        end
    end

    for (genvar s = 0; s < N_SLAVE; s++) begin : g_arb
`ifdef NAIVE_BUS_XBAR_RR_EN
        logic slave_fire;
        assign slave_fire = (slave_rd_req[s] & slave_rd_gnt[s]) |
                            (slave_wr_req[s] & slave_wr_gnt[s]);
`endif
        naive_bus_arbiter #(
            .N_MASTER (N_MASTER)
        ) u_arb (
`ifdef NAIVE_BUS_XBAR_RR_EN
            .clk       (clk),
            .rst       (rst),
            .slave_gnt (slave_fire),
`endif
            .req       (arb_req[s]),
            .grant     (arb_gnt[s])
        );
    end

    // Route the winner's fields to its slave; idle ports are driven to zero
    always_comb begin
        slave_rd_req  = '0;
        slave_rd_addr = '0;
        slave_wr_req  = '0;
        slave_wr_addr = '0;
        slave_wr_byte = '0;
        slave_wr_data = '0;
        for (int s = 0; s < N_SLAVE; s++) begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (arb_gnt[s][m]) begin
                    if (act_kind[m] == ACC_READ) begin
                        slave_rd_req[s]           = 1'b1;
                        slave_rd_addr[s*32 +: 32] = master_rd_addr[m*32 +: 32];
                    end else begin
                        slave_wr_req[s]           = 1'b1;
                        slave_wr_addr[s*32 +: 32] = master_wr_addr[m*32 +: 32];
                        slave_wr_byte[s*4 +: 4]   = master_wr_byte[m*4 +: 4];
                        slave_wr_data[s*32 +: 32] = master_wr_data[m*32 +: 32];
                    end
                end
            end
        end
    end

    // Unmapped accesses are granted locally without touching any slave
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            route_gnt[m] = 1'b0;
            for (int s = 0; s < N_SLAVE; s++) begin
                if (arb_gnt[s][m]) begin
                    route_gnt[m] = (act_kind[m] == ACC_READ) ? slave_rd_gnt[s] : slave_wr_gnt[s];
                end
            end
            err_hit[m] = !rst && (act_kind[m] != ACC_NONE) &&
                         (act_dst[m] == SIDX_W'(ERR_IDX));
            master_rd_gnt[m] = (route_gnt[m] | err_hit[m]) && (act_kind[m] == ACC_READ);
            master_wr_gnt[m] = (route_gnt[m] | err_hit[m]) && (act_kind[m] == ACC_WRITE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= '0;
            for (int m = 0; m < N_MASTER; m++) begin
                rd_src_q[m] <= '0;
            end
        end else begin
            rd_valid_q <= master_rd_gnt;
            for (int m = 0; m < N_MASTER; m++) begin
                if (master_rd_gnt[m]) begin
                    rd_src_q[m] <= act_dst[m];
                end
            end
        end
    end

    always_comb begin
        master_rd_data = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            if (rd_valid_q[m]) begin
                if (rd_src_q[m] == SIDX_W'(ERR_IDX)) begin
                    master_rd_data[m*32 +: 32] = ERR_RDATA;
                end else begin
                    for (int s = 0; s < N_SLAVE; s++) begin
                        if (rd_src_q[m] == SIDX_W'(s)) begin
                            master_rd_data[m*32 +: 32] = slave_rd_data[s*32 +: 32];
                        end
                    end
                end
            end
        end
    end

    // Several masters may fault in one cycle, so the counter adds their number
    always_comb begin
        err_num = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            err_num = err_num + ECNT_W'(err_hit[m]);
        end
        err_sum = {1'b0, err_cnt_q} + 17'(err_num);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= |err_hit;
            err_cnt_q   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign o_err_pulse = err_pulse_q;
    assign o_err_cnt   = err_cnt_q;

endmodule
